// File: rtl/gt_stream_out_pkg.sv
// Shared types and constants for the garbled-table stream-out block.
// Header layout is used only when GT_STREAM_HDR_EN is defined.
package gt_stream_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH + 1);

  // Header word: table count, LSB-aligned, S bits wide, zero above.
  localparam int HDR_CNT_LSB = 0;

endpackage

// File: rtl/gt_stream_out_fifo.sv
// 4-deep word FIFO; accepts up to two words per cycle (slot 0 first).
// Same-cycle push and pop are allowed.
module gt_word_fifo
  import gt_stream_out_pkg::*;
#(
  parameter int K = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           push,
  input  logic [1:0][K-1:0]    push_data,
  input  logic                 pop,
  output logic [K-1:0]         head,
  output logic [FIFO_CW-1:0]   count
);

  logic [K-1:0]       mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr;
  logic [FIFO_PW-1:0] rd_ptr;
  logic [FIFO_PW-1:0] wr_nxt;

  assign wr_nxt = wr_ptr + FIFO_PW'(push[0]);
  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push[0])
        mem[wr_ptr] <= push_data[0];
      if (push[1])
        mem[wr_nxt] <= push_data[1];
      wr_ptr <= wr_nxt + FIFO_PW'(push[1]);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_PW'(1);
      count <= count + FIFO_CW'(push[0])
             + FIFO_CW'(push[1]) - FIFO_CW'(pop);
    end
  end

endmodule

// File: rtl/gt_stream_out.sv
// Streams garbled-table pairs from the GT DPRAM as K-bit valid/ready words.
// Optional GT_STREAM_HDR_EN prepends a table-count header word.
module gt_stream_out
  import gt_stream_out_pkg::*;
#(
  parameter int S = 20,
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S-1:0] num_gt,
  input  logic [S-1:0] gt_avail,
  output logic [S-1:0] rd_addr_0,
  output logic [S-1:0] rd_addr_1,
  input  logic [K-1:0] rd_data_0,
  input  logic [K-1:0] rd_data_1,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int RW = S + 2;
  localparam int OW = FIFO_CW + 1;

  state_e state_q, state_d;
  logic [S-1:0] total_q;
  logic [S-1:0] rd_idx_q;
  logic [S-1:0] addr0_q;
  logic [S-1:0] addr1_q;
  logic [S-1:0] a0;
  logic [S-1:0] a1;
  logic [RW-1:0] rem_q;
  logic infl_q;
  logic accept;
  logic issue;
  logic room;
  logic pop;
  logic [OW-1:0] occ;
  logic [OW-1:0] lim;
  logic [FIFO_CW-1:0] count;
  logic [K-1:0] head;
  logic [1:0] push;
  logic [1:0][K-1:0] push_data;
  logic hdr_push;
  logic [K-1:0] hdr_data;
  logic [RW-1:0] hdr_w;

`ifdef GT_STREAM_HDR_EN
  assign hdr_push = accept;
  assign hdr_data = K'(num_gt) << HDR_CNT_LSB;
  assign hdr_w = RW'(1);
`else
  assign hdr_push = 1'b0;
  assign hdr_data = '0;
  assign hdr_w = '0;
`endif

  assign accept = (state_q == IDLE) && start;
  assign out_valid = (count != '0);
  assign out_data = head;
  assign pop = out_valid && out_ready;
  assign out_last = out_valid && (rem_q == RW'(1));
  assign busy = (state_q == FETCH) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // Slots claimed by buffered and in-flight words, crediting this cycle's pop.
  assign occ = {1'b0, count} + (infl_q ? OW'(2) : OW'(0));
  assign lim = OW'(2) + OW'(pop);
  assign room = (occ <= lim);

  assign issue = (state_q == FETCH)
              && (rd_idx_q < gt_avail)
              && (rd_idx_q < total_q)
              && room;

  assign a0 = {rd_idx_q[S-2:0], 1'b0};
  assign a1 = {rd_idx_q[S-2:0], 1'b1};
  assign rd_addr_0 = issue ? a0 : addr0_q;
  assign rd_addr_1 = issue ? a1 : addr1_q;

  always_comb begin
    push = {1'b0, hdr_push};
    push_data = {K'(0), hdr_data};
    if (infl_q) begin
      push = 2'b11;
      push_data = {rd_data_1, rd_data_0};
    end
  end

  gt_word_fifo #(.K(K)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (rd_idx_q == total_q) state_d = DRAIN;
      DRAIN: if (!infl_q && count == FIFO_CW'(pop))
               state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      total_q <= '0;
      rd_idx_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      rem_q <= '0;
      infl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      infl_q <= issue;
      if (accept) begin
        total_q <= num_gt;
        rd_idx_q <= '0;
        rem_q <= RW'({num_gt, 1'b0}) + hdr_w;
      end else begin
        if (pop)
          rem_q <= rem_q - RW'(1);
        if (issue) begin
          rd_idx_q <= rd_idx_q + S'(1);
          addr0_q <= a0;
          addr1_q <= a1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gt_stream_out.sv
// Directed bench for gt_stream_out; memory word j holds value j.
// Build with +define+GT_STREAM_HDR_EN to exercise header mode.
module tb_gt_stream_out;

  localparam int S = 20;
  localparam int K = 128;
`ifdef GT_STREAM_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [S-1:0] num_gt = '0;
  logic [S-1:0] gt_avail = '0;
  logic [S-1:0] rd_addr_0, rd_addr_1;
  logic [K-1:0] rd_data_0 = '0;
  logic [K-1:0] rd_data_1 = '0;
  logic [K-1:0] out_data;
  logic out_valid, out_last, busy, done;
  logic out_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [K-1:0] got_q[$];
  bit last_q[$];
  int cyc_q[$];
  bit pv = 0;
  logic [K-1:0] pd = '0;
  logic [S-1:0] paddr = '0;

  gt_stream_out #(.S(S), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_gt    (num_gt),
    .gt_avail  (gt_avail),
    .rd_addr_0 (rd_addr_0),
    .rd_addr_1 (rd_addr_1),
    .rd_data_0 (rd_data_0),
    .rd_data_1 (rd_data_1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data_0 <= K'(rd_addr_0);
    rd_data_1 <= K'(rd_addr_1);
  end

  task automatic chk(string tag, logic [K-1:0] got, logic [K-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      pv = 0;
      paddr = '0;
    end else begin
      assert (dut.u_fifo.count <= 4);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        cyc_q.push_back(cyc - t0);
      end
      if (pv) begin
        chk("hold_valid", K'(out_valid), K'(1));
        chk("hold_data", out_data, pd);
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      if (rd_addr_0 != paddr)
        chk("issue_avail", K'((rd_addr_0 >> 1) < gt_avail), K'(1));
      paddr = rd_addr_0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
        chk("busy_at_done", K'(busy), K'(0));
      end
    end
  end

  task automatic start_run(int n);
    got_q.delete();
    last_q.delete();
    cyc_q.delete();
    done_cnt = 0;
    num_gt = S'(n);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++)
      @(posedge clk);
    #1;
    chk("done_seen", K'(done_cnt), K'(1));
  endtask

  task automatic check_stream(int n);
    int cnt;
    int m;
    cnt = 2 * n + HDR;
    chk("nwords", K'(got_q.size()), K'(cnt));
    m = (got_q.size() < cnt) ? got_q.size() : cnt;
    for (int i = 0; i < m; i++) begin
      chk("word", got_q[i],
          (HDR == 1 && i == 0) ? K'(n) : K'(i - HDR));
      chk("last", K'(last_q[i]), K'(i == cnt - 1));
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", K'(out_valid), K'(0));
    chk("rst_data", out_data, K'(0));
    chk("rst_last", K'(out_last), K'(0));
    chk("rst_busy", K'(busy), K'(0));
    chk("rst_done", K'(done), K'(0));
    chk("rst_addr0", K'(rd_addr_0), K'(0));
    chk("rst_addr1", K'(rd_addr_1), K'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // basic
    gt_avail = S'(3);
    out_ready = 1'b1;
    start_run(3);
    chk("busy_c1", K'(busy), K'(1));
    wait_done(50);
    check_stream(3);
    if (HDR == 0)
      for (int i = 0; i < got_q.size(); i++)
        chk("word_cyc", K'(cyc_q[i]), K'(3 + i));
    chk("done_cyc", K'(done_cyc), K'(9));
    repeat (2) @(posedge clk);
    #1;

    // producer-limited
    gt_avail = '0;
    start_run(4);
    repeat (10) @(posedge clk);
    #1;
    chk("stall0_words", K'(got_q.size()), K'(HDR));
    gt_avail = S'(1);
    repeat (10) @(posedge clk);
    #1;
    chk("stall1_words", K'(got_q.size()), K'(2 + HDR));
    gt_avail = S'(4);
    wait_done(60);
    check_stream(4);
    repeat (2) @(posedge clk);
    #1;

    // backpressure
    gt_avail = S'(5);
    start_run(5);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      out_ready = ($urandom_range(0, 9) < 3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk("bp_done_seen", K'(done_cnt), K'(1));
    check_stream(5);
    repeat (2) @(posedge clk);
    #1;

    // empty
    start_run(0);
    wait_done(20);
    check_stream(0);
    if (HDR == 0)
      chk("empty_done_cyc", K'(done_cyc), K'(3));
    repeat (2) @(posedge clk);
    #1;

    // reset mid-stream, then restart
    gt_avail = S'(4);
    start_run(4);
    for (int i = 0; i < 20 && got_q.size() < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_words", K'(got_q.size() >= 3), K'(1));
    rst = 1'b0;
    #1;
    chk_reset_vals();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_rst", K'(done_cnt), K'(0));
    start_run(4);
    wait_done(50);
    check_stream(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gt_stream_out.md
# gt_stream_out

Downstream consumer of the garbler's garbled-table memory. It reads garbled-table pairs (t0, t1) from the read ports of the garbled-table DPRAM as the garbler produces them, and serializes them into a K-bit valid/ready word stream toward the host/transport interface. It runs concurrently with garbling: table i is fetched only once the garbler reports more than i tables written.

## Interface

Parameters:
- S, 20: address/counter width (matches garbler netlist width).
- K, 128: label/table word width.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse; begins a stream. Ignored unless in IDLE.
- num_gt, in, S: total garbled tables for this circuit; sampled on the start cycle.
- gt_avail, in, S: tables fully written so far; monotone non-decreasing during a run.
- rd_addr_0, out, S: GT memory read address, even word (t0).
- rd_addr_1, out, S: GT memory read address, odd word (t1).
- rd_data_0, in, K: t0, valid one cycle after rd_addr_0.
- rd_data_1, in, K: t1, valid one cycle after rd_addr_1.
- out_data, out, K: stream word.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: sink accepts the word when out_valid && out_ready.
- out_last, out, 1: marks the final word of the stream.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse after the final word is accepted.

## Operation

- States:
  - IDLE: on start, latch num_gt into total, clear rd_idx and the FIFO, and go to FETCH.
  - FETCH: issue reads until rd_idx == total, then go to DRAIN.
  - DRAIN: wait for the FIFO and in-flight reads to empty, then go to DONE.
  - DONE: pulse done, then return to IDLE.
- Read issue happens in FETCH when all of the following hold: rd_idx < gt_avail, rd_idx < total, and FIFO free slots minus in-flight words ≥ 2.
  - The block drives rd_addr_0 = 2*rd_idx and rd_addr_1 = 2*rd_idx+1, both truncated to S bits. rd_idx increments.
- One cycle later, t0 then t1 are pushed into a 4-word FIFO. If both arrive in the same cycle, t0 takes the lower slot.
- The FIFO head drives out_data and out_valid. A pop occurs on out_valid && out_ready.
- out_last = out_valid && this is the final stream word (t1 of table total-1).
- When not issuing, rd_addr_0/1 hold their last values (don't-care for the memory).
- Boundary conditions:
  - num_gt = 0: go straight FETCH→DRAIN→DONE with no words emitted (see the configuration section for header mode).
  - gt_avail stalls: issuing pauses; the output drains whatever is buffered.
  - FIFO full with out_ready low: no issue; out_data and out_valid hold stable (AXI-style; data must not change while valid && !ready).
  - Push and pop in the same cycle are both allowed; occupancy changes by the net amount.
  - start while busy is ignored.
  - rst asserted mid-stream: the stream is abandoned, all state is cleared, and no done pulse is produced.
- Reset values: state IDLE, rd_idx 0, FIFO empty, rd_addr_0 = 0, rd_addr_1 = 0, out_data = 0, out_valid = 0, out_last = 0, busy = 0, done = 0.

## Timing

- The start pulse is in cycle 0. FETCH begins in cycle 1, and the first read issues in cycle 1 if gt_avail > 0.
- Data is captured at the end of cycle 2. out_valid for t0 is first high in cycle 3.
- Steady state with out_ready held high: 1 word/cycle, no bubbles. The 4-deep FIFO covers the 1-cycle read latency plus the 2-word issue granularity.
- done pulses in the cycle after the handshake of the out_last word. busy falls in the same cycle that done pulses.

## Configuration

- GT_STREAM_HDR_EN defined:
  - A header word {(K-S) zeros, total} is pushed into the FIFO on entry to FETCH, ahead of all tables.
  - The header is emitted before t0 of table 0, and in-flight/free accounting includes it.
  - With num_gt = 0, the header is the only word and carries out_last.
- GT_STREAM_HDR_EN undefined: there is no header, the stream is tables only, and num_gt = 0 emits nothing.

## Structure

- The shared package holds:
  - The state enum: IDLE, FETCH, DRAIN, DONE.
  - The FIFO depth constant (4).
  - The header layout constant (count field width S, LSB-aligned).
- One sub-module, gt_word_fifo: a synchronous 4×K FIFO.
  - Ports: push, push_data, pop, head, count.
  - Same-cycle push and pop are supported.
  - It contains the only storage for in-flight words.
- The FSM, issue logic, in-flight counter (0–2 words) and last-word tracking stay in gt_stream_out.

## Test plan

- Basic: num_gt = 3, gt_avail = 3 before start, out_ready = 1, memory word j = j.
  - Expect 6 words 0..5 on cycles 3–8, out_last on word 5, done on cycle 9.
- Producer-limited: num_gt = 4, gt_avail steps 0→1→4 with 10-cycle gaps.
  - Expect words 0,1, then a stall, then 2..7.
  - Expect no read issued with rd_idx ≥ gt_avail.
- Backpressure: num_gt = 5, out_ready random at 30%.
  - Expect all 10 words in order, with data stable while out_valid && !out_ready.
  - Expect the FIFO never to overflow (assertion).
- Empty: num_gt = 0.
  - Without the macro: done two cycles after FETCH, with zero words.
  - With GT_STREAM_HDR_EN: a single header word 0 with out_last.
- Reset mid-stream: assert rst after 3 words of num_gt = 4.
  - Expect all outputs to go to their reset values immediately, and no done pulse.
  - A new start after release streams from word 0.
- Header: GT_STREAM_HDR_EN, num_gt = 2.
  - Expect header value 2, then words 0..3, with out_last on word 3.
